// File: rtl/mmio_debug_port.sv
// MMIO debug sink: PRINT channels into a FIFO stream, DONE/exit code, STATUS, CLEAR.
// Ports: clk/n_rst, mem_* bus, out_* stream, done/exit_code/timeout. Macro: MMIO_DBG_TIMEOUT_EN.
module mmio_debug_port #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 'hFFFF_0000,
  parameter int NUM_CHANNELS = 4,
  parameter int FIFO_DEPTH = 16,
  parameter int TIMEOUT_CYCLES = 100000,
  localparam int CW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  mem_wr_en,
  input  logic                  mem_rd_en,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CW-1:0]         out_channel,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] exit_code,
  output logic                  timeout
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW-1:0] P_ONE = 1;
  localparam logic [PW:0] C_ONE = 1;
  localparam logic [PW:0] C_FULL = FIFO_DEPTH;
  localparam logic [ADDR_WIDTH-1:0] A_PRN = 4 * NUM_CHANNELS;
  localparam logic [ADDR_WIDTH-1:0] A_DONE = 'h40;
  localparam logic [ADDR_WIDTH-1:0] A_STAT = 'h44;
  localparam logic [ADDR_WIDTH-1:0] A_CLR = 'h48;

  typedef enum logic [1:0] {RUN, DONE_S, TO_S} state_t;

  state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0] off;
  logic hit_prn, hit_done, hit_stat, hit_clr;
  logic wr_prn, wr_done, wr_clr;
  logic [CW-1:0] wr_ch;

  logic [DATA_WIDTH-1:0] dat_q [FIFO_DEPTH];
  logic [CW-1:0] chn_q [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [PW:0] count;
  logic full, empty, push, pop, drop;
  logic overflow;
  logic [15:0] drop_cnt;
  logic [DATA_WIDTH-1:0] status;
  logic wd_exp;

  assign off = mem_addr - BASE_ADDR;
  assign hit_prn = (off[1:0] == 2'b00) && (off < A_PRN);
  assign hit_done = (off == A_DONE);
  assign hit_stat = (off == A_STAT);
  assign hit_clr = (off == A_CLR);
  assign wr_ch = off[CW+1:2];

  assign wr_prn = mem_wr_en && hit_prn && (state_q == RUN);
  assign wr_done = mem_wr_en && hit_done && (state_q == RUN);
  assign wr_clr = mem_wr_en && hit_clr;

  assign empty = (count == '0);
  assign full = (count == C_FULL);
  assign out_valid = !empty;
  assign pop = out_valid && out_ready;
  // A pop frees the head slot in the same edge, so a full FIFO still takes it.
  assign push = wr_prn && (!full || pop);
  assign drop = wr_prn && full && !pop;

  assign out_data = out_valid ? dat_q[rd_ptr] : '0;
  assign out_channel = out_valid ? chn_q[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push) begin
      dat_q[wr_ptr] <= mem_wr_data;
      chn_q[wr_ptr] <= wr_ch;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + P_ONE;
      if (pop) rd_ptr <= rd_ptr + P_ONE;
      if (push && !pop) count <= count + C_ONE;
      else if (pop && !push) count <= count - C_ONE;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (wr_clr) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
  end

  always_comb begin
    status = '0;
    status[0] = done;
    status[1] = timeout;
    status[2] = overflow;
    status[3] = empty;
    status[4] = full;
    status[15:8] = 8'(count);
    status[31:16] = drop_cnt;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) mem_rd_data <= '0;
    else if (mem_rd_en) mem_rd_data <= hit_stat ? status : '0;
  end

`ifdef MMIO_DBG_TIMEOUT_EN
  logic [31:0] wd_q;
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) wd_q <= '0;
    else if (state_q == RUN) wd_q <= wd_q + 32'd1;
  end
  assign wd_exp = (state_q == RUN) && (wd_q == 32'(TIMEOUT_CYCLES - 1));
  assign timeout = (state_q == TO_S);
`else
  assign wd_exp = 1'b0;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_q <= RUN;
    else state_q <= state_d;
  end

  // DONE wins over a watchdog expiry landing in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (wr_done) state_d = DONE_S;
        else if (wd_exp) state_d = TO_S;
      end
      default: state_d = state_q;
    endcase
  end

  assign done = (state_q == DONE_S);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) exit_code <= '0;
    else if (wr_done) exit_code <= mem_wr_data;
  end
endmodule

// File: tb/tb_mmio_debug_port.sv
// Bench for mmio_debug_port: scoreboard queue of expected stream entries.
// Define MMIO_DBG_TIMEOUT_EN to exercise the watchdog path.
module tb_mmio_debug_port;
  localparam logic [31:0] BASE = 32'hFFFF_0000;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic mem_wr_en = 1'b0;
  logic mem_rd_en = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wr_data = '0;
  logic [31:0] mem_rd_data;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [1:0] out_channel;
  logic [31:0] out_data;
  logic done;
  logic [31:0] exit_code;
  logic timeout;

  int total = 0;
  int bad = 0;
  logic [33:0] sb [$];

  always #5 clk = ~clk;

  mmio_debug_port #(
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk(clk),
    .n_rst(n_rst),
    .mem_wr_en(mem_wr_en),
    .mem_rd_en(mem_rd_en),
    .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data),
    .mem_rd_data(mem_rd_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_channel(out_channel),
    .out_data(out_data),
    .done(done),
    .exit_code(exit_code),
    .timeout(timeout)
  );

  always @(negedge clk) begin
    if (n_rst === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      logic [33:0] e;
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL stream_extra got ch=%0d data=%0h", out_channel, out_data);
      end else begin
        e = sb.pop_front();
        if ({out_channel, out_data} !== e) begin
          bad++;
          $display("FAIL stream got=%0h want=%0h", {out_channel, out_data}, e);
        end
      end
    end
  end

  task automatic wr(input logic [31:0] o, input logic [31:0] d);
    mem_addr = BASE + o;
    mem_wr_data = d;
    mem_wr_en = 1'b1;
    @(posedge clk);
    #1;
    mem_wr_en = 1'b0;
  endtask

  task automatic prn(input int ch, input logic [31:0] d);
    logic [1:0] c;
    c = 2'(ch);
    sb.push_back({c, d});
    wr(32'(4 * ch), d);
  endtask

  task automatic rd(input logic [31:0] o, output logic [31:0] q);
    mem_addr = BASE + o;
    mem_rd_en = 1'b1;
    @(posedge clk);
    #1;
    mem_rd_en = 1'b0;
    q = mem_rd_data;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    mem_wr_en = 1'b0;
    mem_rd_en = 1'b0;
    out_ready = 1'b0;
    sb.delete();
    @(posedge clk);
    #1;
    n_rst = 1'b1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while (sb.size() != 0 && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_left", 32'(sb.size()), 32'd0);
    chk("drain_valid", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] q;
    do_reset();
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_ch", {30'd0, out_channel}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_exit", exit_code, 32'd0);
    chk("rst_to", {31'd0, timeout}, 32'd0);
    chk("rst_rd", mem_rd_data, 32'd0);
    rd(32'h44, q);
    chk("rst_status", q, 32'h0000_0008);
    wr(32'h10, 32'd9);
    chk("bad_chan", {31'd0, out_valid}, 32'd0);
    rd(32'h00, q);
    chk("rd_print", q, 32'd0);
    rd(32'h4C, q);
    chk("rd_unmapped", q, 32'd0);
  endtask

  task automatic test_print();
    do_reset();
    out_ready = 1'b1;
    prn(1, 32'd42);
    chk("p_valid", {31'd0, out_valid}, 32'd1);
    chk("p_ch", {30'd0, out_channel}, 32'd1);
    chk("p_data", out_data, 32'd42);
    @(posedge clk);
    #1;
    chk("p_popped", {31'd0, out_valid}, 32'd0);
    for (int i = 0; i < 4; i++) prn(i, 32'(100 + i));
    drain();
  endtask

  task automatic test_overflow();
    logic [31:0] q;
    do_reset();
    for (int i = 0; i < 16; i++) prn(0, 32'(i));
    wr(32'h0, 32'd16);
    rd(32'h44, q);
    chk("ovf_status", q, 32'h0001_1014);
    drain();
    wr(32'h48, 32'h0);
    rd(32'h44, q);
    chk("clr_status", q, 32'h0000_0008);
  endtask

  task automatic test_full_pop();
    logic [31:0] q;
    do_reset();
    for (int i = 0; i < 16; i++) prn(2, 32'(i));
    out_ready = 1'b1;
    prn(0, 32'hAA);
    out_ready = 1'b0;
    rd(32'h44, q);
    chk("fp_status", q, 32'h0000_1010);
    drain();
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 12; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      prn(i % 4, $urandom);
    end
    drain();
  endtask

  task automatic test_done();
    logic [31:0] q;
    do_reset();
    prn(2, 32'h11);
    prn(3, 32'h22);
    wr(32'h40, 32'd7);
    chk("d_done", {31'd0, done}, 32'd1);
    chk("d_exit", exit_code, 32'd7);
    wr(32'h0, 32'd5);
    rd(32'h44, q);
    chk("d_status", q, 32'h0000_0201);
    drain();
    chk("d_sticky", {31'd0, done}, 32'd1);
  endtask

  task automatic test_timeout();
    logic [31:0] q;
    do_reset();
    repeat (99) @(posedge clk);
    #1;
    chk("to_early", {31'd0, timeout}, 32'd0);
    @(posedge clk);
    #1;
`ifdef MMIO_DBG_TIMEOUT_EN
    chk("to_fire", {31'd0, timeout}, 32'd1);
    wr(32'h40, 32'd3);
    chk("to_nodone", {31'd0, done}, 32'd0);
    rd(32'h44, q);
    chk("to_status", q, 32'h0000_000A);
`else
    chk("to_off", {31'd0, timeout}, 32'd0);
    wr(32'h40, 32'd3);
    chk("to_done", {31'd0, done}, 32'd1);
    rd(32'h44, q);
    chk("to_status", q, 32'h0000_0009);
`endif
  endtask

  task automatic test_async_reset();
    logic [31:0] q;
    do_reset();
    for (int i = 0; i < 5; i++) prn(i % 4, 32'(i + 7));
    wr(32'h40, 32'd1);
    rd(32'h44, q);
    chk("ar_pre", q, 32'h0000_0501);
    #2;
    n_rst = 1'b0;
    #1;
    chk("ar_valid", {31'd0, out_valid}, 32'd0);
    chk("ar_done", {31'd0, done}, 32'd0);
    chk("ar_exit", exit_code, 32'd0);
    chk("ar_data", out_data, 32'd0);
    chk("ar_rd", mem_rd_data, 32'd0);
    sb.delete();
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    rd(32'h44, q);
    chk("ar_status", q, 32'h0000_0008);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench stalled");
  end

  initial begin
    test_reset();
    test_print();
    test_overflow();
    test_full_pop();
    test_back_to_back();
    test_done();
    test_timeout();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
